// File: rtl/bocks_upload_ctrl_if.sv
// bocks_upload_ctrl_if
// Bundles the two buses that bocks_upload_ctrl bridges:
//   - the hps_io ioctl upload side (upload/index/rd/addr in, din/wait out)
//   - the byte-wide on-chip memory read port (rd/addr out, dout/busy in)
// Modports:
//   master : the surrounding system (hps_io + memory), drives requests and read data
//   slave  : the upload controller, answers requests and drives the memory port
interface bocks_upload_ctrl_if #(
  parameter int MEM_AW = 16
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [26:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic              mem_busy;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout, mem_busy,
    input  ioctl_din, ioctl_wait, mem_rd, mem_addr
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout, mem_busy,
    output ioctl_din, ioctl_wait, mem_rd, mem_addr
  );
endinterface

// File: rtl/bocks_upload_ctrl.sv
// bocks_upload_ctrl
// Core-side responder for the HPS ioctl upload (core-to-Linux) path. Each
// byte-read request from hps_io becomes one read on a byte-wide memory port;
// ioctl_wait stalls the HPS until the byte sits on ioctl_din. Reads at or
// above SIZE are answered immediately with 8'hFF and never touch memory.
// Ports:
//   clk_sys     : system clock, all logic on the rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : ioctl upload + memory read port (slave modport)
//   upload_done : one-cycle pulse when a session that sent bytes ends
//   bytes_sent  : bytes returned in the current or last session (saturating)
//   overrun     : sticky, a read arrived while a previous one was in flight
module bocks_upload_ctrl #(
  parameter int         MEM_AW       = 16,
  parameter int         RD_LAT       = 2,
  parameter logic [7:0] UPLOAD_INDEX = 8'h01,
  parameter int         SIZE         = 65536
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  bocks_upload_ctrl_if.slave  bus,
  output logic                upload_done,
  output logic [26:0]         bytes_sent,
  output logic                overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0]  LAT    = RD_LAT[2:0];
  localparam logic [31:0] SIZE_W = SIZE;

  logic [1:0]        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [26:0]       bytes_q, bytes_d;
  logic              overrun_q, overrun_d;
  logic              done_q, done_d;
  logic              active_q;

  logic        active;
  logic        sess_start;
  logic        sess_end;
  logic        addr_oor;
  logic [26:0] bytes_base;
  logic [26:0] bytes_inc;

  assign active     = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
  assign sess_start = active && !active_q;
  assign sess_end   = !active && active_q;
  assign addr_oor   = {5'd0, bus.ioctl_addr} >= SIZE_W;

  // A session start clears the count before any increment in the same cycle,
  // so a read coinciding with the start ends with bytes_sent == 1.
  assign bytes_base = sess_start ? 27'd0 : bytes_q;
  assign bytes_inc  = (bytes_base == {27{1'b1}}) ? bytes_base : bytes_base + 27'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    din_d      = din_q;
    wait_d     = wait_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    bytes_d    = bytes_base;
    overrun_d  = sess_start ? 1'b0 : overrun_q;
    done_d     = sess_end && (bytes_q != 27'd0);

    if (state_q == S_IDLE) begin
      if (bus.ioctl_rd && active) begin
        if (addr_oor) begin
          din_d   = 8'hFF;
          bytes_d = bytes_inc;
        end else begin
          addr_d  = bus.ioctl_addr[MEM_AW-1:0];
          wait_d  = 1'b1;
          state_d = S_REQ;
        end
      end
    end else if (!active) begin
      // Session abort: drop the outstanding read without counting it.
      state_d = S_IDLE;
      wait_d  = 1'b0;
    end else begin
      if (bus.ioctl_rd) begin
        overrun_d = 1'b1;
      end
      case (state_q)
        S_REQ: begin
          if (!bus.mem_busy) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            cnt_d      = LAT;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter hits zero on this edge: RD_LAT edges after the mem_rd edge.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            din_d   = bus.mem_dout;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          wait_d  = 1'b0;
          bytes_d = bytes_inc;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= 3'd0;
      bytes_q    <= 27'd0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      bytes_q    <= bytes_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      active_q   <= active;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign upload_done    = done_q;
  assign bytes_sent     = bytes_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_bocks_upload_ctrl.sv
// tb_bocks_upload_ctrl
// Directed bench for bocks_upload_ctrl with RD_LAT=2, SIZE=256. A small
// memory model answers each mem_rd with memByte(addr) on the following
// cycle only, so a mistimed capture picks up the idle value 8'h00.
module tb_bocks_upload_ctrl;

  localparam int         MEM_AW = 16;
  localparam int         RD_LAT = 2;
  localparam logic [7:0] IDX    = 8'h01;
  localparam int         SIZE   = 256;

  logic        clk_sys;
  logic        reset_n;
  logic        upload_done;
  logic [26:0] bytes_sent;
  logic        overrun;

  int testsRun;
  int testsFailed;
  int memRdCount;
  int waitCycles;
  int doneCount;

  bocks_upload_ctrl_if #(.MEM_AW(MEM_AW)) busIf ();

  bocks_upload_ctrl #(
    .MEM_AW(MEM_AW),
    .RD_LAT(RD_LAT),
    .UPLOAD_INDEX(IDX),
    .SIZE(SIZE)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(busIf.slave),
    .upload_done(upload_done),
    .bytes_sent(bytes_sent),
    .overrun(overrun)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] memByte(input logic [15:0] a);
    if (a == 16'h0010) return 8'hA5;
    return a[7:0] ^ 8'hC3;
  endfunction

  // Memory model: data valid only in the cycle after the mem_rd cycle.
  always @(posedge clk_sys) begin
    busIf.mem_dout <= busIf.mem_rd ? memByte(busIf.mem_addr) : 8'h00;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (busIf.mem_rd)     memRdCount++;
    if (busIf.ioctl_wait) waitCycles++;
    if (upload_done)      doneCount++;
  endtask

  task automatic clearCounts();
    memRdCount = 0;
    waitCycles = 0;
    doneCount  = 0;
  endtask

  task automatic applyStimulus(input logic upload, input logic [7:0] index,
                               input logic rd, input logic [26:0] addr);
    busIf.ioctl_upload = upload;
    busIf.ioctl_index  = index;
    busIf.ioctl_rd     = rd;
    busIf.ioctl_addr   = addr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one in-session read and waits (bounded) for ioctl_wait to drop.
  task automatic readByte(input logic [26:0] addr);
    applyStimulus(1'b1, IDX, 1'b1, addr);
    tick();
    applyStimulus(1'b1, IDX, 1'b0, addr);
    for (int i = 0; i < 40 && busIf.ioctl_wait; i++) tick();
    if (busIf.ioctl_wait) checkOutput("waitTimeout", 32'd1, 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clearCounts();
    reset_n        = 1'b0;
    busIf.mem_busy = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 27'd0);

    #1;
    checkOutput("rstDin",     {24'd0, busIf.ioctl_din}, 32'h00);
    checkOutput("rstWait",    {31'd0, busIf.ioctl_wait}, 32'd0);
    checkOutput("rstMemRd",   {31'd0, busIf.mem_rd}, 32'd0);
    checkOutput("rstMemAddr", {16'd0, busIf.mem_addr}, 32'd0);
    checkOutput("rstBytes",   {5'd0, bytes_sent}, 32'd0);
    checkOutput("rstOverrun", {31'd0, overrun}, 32'd0);
    checkOutput("rstDone",    {31'd0, upload_done}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Session start
    applyStimulus(1'b1, IDX, 1'b0, 27'd0);
    tick();
    checkOutput("startBytes", {5'd0, bytes_sent}, 32'd0);

    // Basic read at 0x10
    clearCounts();
    applyStimulus(1'b1, IDX, 1'b1, 27'h10);
    tick();
    checkOutput("basicWaitRise", {31'd0, busIf.ioctl_wait}, 32'd1);
    checkOutput("basicNoRdYet",  {31'd0, busIf.mem_rd}, 32'd0);
    applyStimulus(1'b1, IDX, 1'b0, 27'h10);
    tick();
    checkOutput("basicMemRd",   {31'd0, busIf.mem_rd}, 32'd1);
    checkOutput("basicMemAddr", {16'd0, busIf.mem_addr}, 32'h10);
    tick();
    checkOutput("basicMemRdOne", {31'd0, busIf.mem_rd}, 32'd0);
    for (int i = 0; i < 20 && busIf.ioctl_wait; i++) tick();
    checkOutput("basicWaitLen", waitCycles, 32'd4);
    checkOutput("basicDin",     {24'd0, busIf.ioctl_din}, 32'hA5);
    checkOutput("basicBytes",   {5'd0, bytes_sent}, 32'd1);
    checkOutput("basicRdCount", memRdCount, 32'd1);

    // Contention: mem_busy held for 5 cycles in REQ
    clearCounts();
    busIf.mem_busy = 1'b1;
    applyStimulus(1'b1, IDX, 1'b1, 27'h20);
    tick();
    applyStimulus(1'b1, IDX, 1'b0, 27'h20);
    repeat (5) tick();
    checkOutput("busyNoRd",   memRdCount, 32'd0);
    checkOutput("busyWaitHi", {31'd0, busIf.ioctl_wait}, 32'd1);
    busIf.mem_busy = 1'b0;
    for (int i = 0; i < 20 && busIf.ioctl_wait; i++) tick();
    checkOutput("busyWaitLen", waitCycles, 32'd9);
    checkOutput("busyRdCount", memRdCount, 32'd1);
    checkOutput("busyDin",     {24'd0, busIf.ioctl_din}, 32'hE3);
    checkOutput("busyBytes",   {5'd0, bytes_sent}, 32'd2);

    // Out of range (300 >= SIZE)
    clearCounts();
    applyStimulus(1'b1, IDX, 1'b1, 27'd300);
    tick();
    checkOutput("oorDin",   {24'd0, busIf.ioctl_din}, 32'hFF);
    checkOutput("oorBytes", {5'd0, bytes_sent}, 32'd3);
    applyStimulus(1'b1, IDX, 1'b0, 27'd300);
    tick();
    tick();
    checkOutput("oorNoWait", waitCycles, 32'd0);
    checkOutput("oorNoRd",   memRdCount, 32'd0);

    // Overrun during WAIT, then abort
    clearCounts();
    applyStimulus(1'b1, IDX, 1'b1, 27'h30);
    tick();
    applyStimulus(1'b1, IDX, 1'b0, 27'h30);
    tick();
    applyStimulus(1'b1, IDX, 1'b1, 27'h40);
    tick();
    checkOutput("ovrSet", {31'd0, overrun}, 32'd1);
    applyStimulus(1'b0, IDX, 1'b0, 27'h40);
    tick();
    checkOutput("abortWait",  {31'd0, busIf.ioctl_wait}, 32'd0);
    checkOutput("abortDone",  {31'd0, upload_done}, 32'd1);
    checkOutput("abortBytes", {5'd0, bytes_sent}, 32'd3);
    checkOutput("abortDin",   {24'd0, busIf.ioctl_din}, 32'hFF);
    tick();
    checkOutput("abortDonePulse", {31'd0, upload_done}, 32'd0);
    checkOutput("abortRdCount",   memRdCount, 32'd1);
    checkOutput("abortDoneCount", doneCount, 32'd1);
    checkOutput("ovrSticky",      {31'd0, overrun}, 32'd1);

    // Read while inactive is ignored
    clearCounts();
    applyStimulus(1'b0, IDX, 1'b1, 27'h10);
    tick();
    applyStimulus(1'b0, IDX, 1'b0, 27'h10);
    tick();
    checkOutput("inactNoWait", waitCycles, 32'd0);
    checkOutput("inactNoRd",   memRdCount, 32'd0);
    checkOutput("inactBytes",  {5'd0, bytes_sent}, 32'd3);

    // Session start coinciding with an (out-of-range) read
    applyStimulus(1'b1, IDX, 1'b1, 27'd400);
    tick();
    checkOutput("coinBytes",   {5'd0, bytes_sent}, 32'd1);
    checkOutput("coinOverrun", {31'd0, overrun}, 32'd0);
    checkOutput("coinDin",     {24'd0, busIf.ioctl_din}, 32'hFF);
    applyStimulus(1'b0, IDX, 1'b0, 27'd0);
    tick();
    checkOutput("coinEndDone", {31'd0, upload_done}, 32'd1);

    // Full sweep 0..255 in one session
    applyStimulus(1'b1, IDX, 1'b0, 27'd0);
    tick();
    clearCounts();
    for (int a = 0; a < 256; a++) begin
      readByte(27'(a));
      checkOutput("sweepDin", {24'd0, busIf.ioctl_din}, {24'd0, memByte(16'(a))});
    end
    checkOutput("sweepBytes",   {5'd0, bytes_sent}, 32'd256);
    checkOutput("sweepRdCount", memRdCount, 32'd256);
    applyStimulus(1'b0, IDX, 1'b0, 27'd0);
    tick();
    checkOutput("sweepEndDone", {31'd0, upload_done}, 32'd1);

    // Reads on a mismatched slot are ignored and do not pulse upload_done
    applyStimulus(1'b1, 8'h02, 1'b1, 27'h10);
    tick();
    applyStimulus(1'b1, 8'h02, 1'b0, 27'h10);
    tick();
    tick();
    checkOutput("mmNoWait",    {31'd0, busIf.ioctl_wait}, 32'd0);
    checkOutput("mmRdCount",   memRdCount, 32'd256);
    checkOutput("mmBytes",     {5'd0, bytes_sent}, 32'd256);
    checkOutput("mmDoneCount", doneCount, 32'd1);

    // Async reset in the middle of WAIT
    applyStimulus(1'b1, IDX, 1'b0, 27'd0);
    tick();
    applyStimulus(1'b1, IDX, 1'b1, 27'h50);
    tick();
    applyStimulus(1'b1, IDX, 1'b0, 27'h50);
    tick();
    tick();
    checkOutput("preRstWait", {31'd0, busIf.ioctl_wait}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstDin",   {24'd0, busIf.ioctl_din}, 32'h00);
    checkOutput("midRstWait",  {31'd0, busIf.ioctl_wait}, 32'd0);
    checkOutput("midRstMemRd", {31'd0, busIf.mem_rd}, 32'd0);
    checkOutput("midRstAddr",  {16'd0, busIf.mem_addr}, 32'd0);
    checkOutput("midRstBytes", {5'd0, bytes_sent}, 32'd0);
    checkOutput("midRstOvr",   {31'd0, overrun}, 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    checkOutput("postRstWait", {31'd0, busIf.ioctl_wait}, 32'd0);
    readByte(27'h10);
    checkOutput("postRstDin",   {24'd0, busIf.ioctl_din}, 32'hA5);
    checkOutput("postRstBytes", {5'd0, bytes_sent}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
